alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control sequencer that drives the ALU. Fetches 9-bit instructions, issues the 4-bit ALU opcode, commits results (register write, memory strobes, program counter update) and keeps the carry/overflow flag fed back into the ALU. Sits between instruction memory, register file, data memory and the ALU in the lab processor top level.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width (≥ 8)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  single-cycle pulse; begins execution at PC 0 when idle or halted
- InstrAddr  output  PC_W  instruction memory address (= PC)
- Instr  input  9  instruction word, combinational read of InstrAddr; [8:5] opcode, [4:0] operand fields (not interpreted here)
- AluOp  output  4  opcode to ALU
- AluOut  input  8  ALU result
- AluOverflow  input  1  ALU carry/overflow output
- OverflowIn  output  1  registered flag fed to ALU carry-in
- BranchFlag  input  1  register-file condition bit (R0[0]) for branches
- RegWrEn  output  1  register file write strobe
- MemRdEn  output  1  data memory read enable
- MemWrEn  output  1  data memory write strobe
- Busy  output  1  high while executing
- Done  output  1  high in HALTED until next accepted Start
- CycleCount  output  16  busy-cycle counter (see Configuration)

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, HALTED.
- IDLE/HALTED --Start--> FETCH; PC←0, OverflowIn←0, Done←0. Start in any other state ignored.
- FETCH: IR←Instr; → EXEC.
- EXEC: AluOp=IR[8:5]. Opcode 1011 (halt) → HALTED (PC holds, no strobes). Opcode 0010 (load) → MEM. All others → WB.
- MEM: MemRdEn=1; → WB.
- WB: commit, then → FETCH.
  - RegWrEn=1 for opcodes 0000,0001,0010,0100,0101,0110,0111,1000,1001,1101,1110.
  - MemWrEn=1 for 0011 (store). MemRdEn=1 also in WB for load.
  - OverflowIn←AluOverflow on 0000 (add); ←0 on 1010 (rst); held otherwise.
  - PC: opcode 1100 with BranchFlag=1 → PC←AluOut zero-extended to PC_W; else PC←PC+1 mod 2^PC_W.
- Opcode 1111 (undefined): no strobes, PC+1.
- AluOp=IR[8:5] in EXEC, MEM, WB; 0000 elsewhere.
- Busy=1 in FETCH/EXEC/MEM/WB. Done=1 only in HALTED.

## Timing
- Reset (async, any state): state IDLE, PC 0, IR 0, OverflowIn 0, AluOp 0, RegWrEn/MemRdEn/MemWrEn 0, Busy 0, Done 0, CycleCount 0.
- Non-load instruction: 3 cycles (FETCH, EXEC, WB); load: 4; halt: 2 then HALTED.
- Strobes are Moore outputs from state+IR, asserted exactly one cycle (MemRdEn two cycles for load).
- Start accepted on the edge it is sampled high; FETCH of address 0 the next cycle.
- PC wrap: PC=2^PC_W−1, non-branch → 0.
- Branch to current PC legal (self-loop).
- Reset mid-WB: strobe drops immediately, no commit.

## Configuration
- SEQ_CYCLE_COUNT_EN defined: CycleCount increments every cycle Busy=1, saturates at 0xFFFF, cleared on accepted Start, holds in HALTED.
- Not defined: counter logic omitted, CycleCount tied to 0.

## Test plan
- Reset in EXEC of an add -> all outputs at reset values immediately, no RegWrEn pulse, PC=0.
- Program {add, add, halt}, AluOverflow=1 on first add, 0 on second -> OverflowIn 1 after first WB, 0 after second; Done high 8 cycles after Start; CycleCount=8 (macro on).
- Load at PC 3 -> MemRdEn high 2 cycles, RegWrEn 1 cycle in WB, next fetch InstrAddr=4 four cycles after its FETCH.
- Branch (1100) with AluOut=0x20: BranchFlag=1 -> InstrAddr=0x20; BranchFlag=0 -> PC+1.
- Store then rst with OverflowIn=1 -> MemWrEn one cycle, RegWrEn 0; OverflowIn 0 after rst WB.
- PC_W=8, non-branch at 0xFF -> next InstrAddr 0x00; Start pulses while Busy ignored.

Source files
------------

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle control sequencer for the lab processor ALU. It fetches 9-bit
// instructions from instruction memory, issues the 4-bit ALU opcode, commits
// results (register write, data memory strobes, PC update) and keeps the
// carry/overflow flag that is fed back into the ALU carry-in.
//
// States: IDLE -> FETCH -> EXEC -> (MEM) -> WB -> FETCH ... ; halt -> HALTED.
//
// Parameters:
//   PC_W         program counter / instruction address width (>= 8)
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-high reset
//   Start        one-cycle pulse, starts at PC 0 when IDLE or HALTED
//   InstrAddr    instruction memory address (the PC)
//   Instr        instruction word read combinationally from InstrAddr
//   AluOp        opcode to ALU (IR[8:5] in EXEC/MEM/WB, else 0)
//   AluOut       ALU result, used as branch target
//   AluOverflow  ALU carry/overflow output
//   OverflowIn   registered flag fed to ALU carry-in
//   BranchFlag   register-file condition bit for branches
//   RegWrEn      register file write strobe (WB)
//   MemRdEn      data memory read enable (MEM and WB of a load)
//   MemWrEn      data memory write strobe (WB of a store)
//   Busy         high in FETCH/EXEC/MEM/WB
//   Done         high in HALTED
//   CycleCount   busy-cycle counter
//
// Build option: define SEQ_CYCLE_COUNT_EN to include the saturating busy-cycle
// counter; otherwise CycleCount is tied to zero.
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    output logic [PC_W-1:0] InstrAddr,
    input  logic [8:0]      Instr,
    output logic [3:0]      AluOp,
    input  logic [7:0]      AluOut,
    input  logic            AluOverflow,
    output logic            OverflowIn,
    input  logic            BranchFlag,
    output logic            RegWrEn,
    output logic            MemRdEn,
    output logic            MemWrEn,
    output logic            Busy,
    output logic            Done,
    output logic [15:0]     CycleCount
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0010;
    localparam logic [3:0] OP_STORE  = 4'b0011;
    localparam logic [3:0] OP_RST    = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1011;
    localparam logic [3:0] OP_BRANCH = 4'b1100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic            overflow_q;
    logic [3:0]      opcode;
    logic            start_ok;

    // Operand fields are consumed by the register file, not by the sequencer.
    logic unused_operand;
    assign unused_operand = ^ir[4:0];

    assign opcode     = ir[8:5];
    assign start_ok   = Start && (state == S_IDLE || state == S_HALTED);
    assign InstrAddr  = pc;
    assign OverflowIn = overflow_q;

    function automatic logic writes_reg(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
            4'b0111, 4'b1000, 4'b1001, 4'b1101, 4'b1110: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Moore outputs: strobes depend only on state and IR, so an async reset
    // drops them immediately and nothing is committed.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would infer a latch.
        next_state = state;
        AluOp      = 4'b0000;
        RegWrEn    = 1'b0;
        MemRdEn    = 1'b0;
        MemWrEn    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) next_state = S_FETCH;
            end
            S_HALTED: begin
                Done = 1'b1;
                if (Start) next_state = S_FETCH;
            end
            S_FETCH: begin
                Busy       = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                Busy  = 1'b1;
                AluOp = opcode;
                if (opcode == OP_HALT)      next_state = S_HALTED;
                else if (opcode == OP_LOAD) next_state = S_MEM;
                else                        next_state = S_WB;
            end
            S_MEM: begin
                Busy       = 1'b1;
                AluOp      = opcode;
                MemRdEn    = 1'b1;
                next_state = S_WB;
            end
            S_WB: begin
                Busy       = 1'b1;
                AluOp      = opcode;
                RegWrEn    = writes_reg(opcode);
                MemWrEn    = (opcode == OP_STORE);
                MemRdEn    = (opcode == OP_LOAD);
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // PC, IR and carry flag. PC holds through FETCH/EXEC and only moves at
    // the end of WB, so a halt leaves it pointing at the halt instruction.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc         <= '0;
            ir         <= '0;
            overflow_q <= 1'b0;
        end else if (start_ok) begin
            pc         <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: ir <= Instr;
                S_WB: begin
                    if (opcode == OP_BRANCH && BranchFlag) pc <= PC_W'(AluOut);
                    else                                   pc <= pc + 1'b1;
                    if (opcode == OP_ADD)      overflow_q <= AluOverflow;
                    else if (opcode == OP_RST) overflow_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                               cycle_count <= '0;
        else if (start_ok)                       cycle_count <= '0;
        else if (Busy && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
    end

    assign CycleCount = cycle_count;
`else
    assign CycleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer. Small program images are loaded into a
// behavioural instruction memory; per-address tables drive AluOut,
// AluOverflow and BranchFlag. Expected per-cycle output snapshots are queued
// when a program is launched and popped/compared each falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int PC_W = 8;

`ifdef SEQ_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    // Flag field order: {RegWrEn, MemRdEn, MemWrEn, Busy, Done, OverflowIn}
    localparam logic [5:0] IDL  = 6'h00;
    localparam logic [5:0] DN   = 6'h02;
    localparam logic [5:0] B0   = 6'h04;
    localparam logic [5:0] B1   = 6'h05;
    localparam logic [5:0] MW0  = 6'h0C;
    localparam logic [5:0] MW1  = 6'h0D;
    localparam logic [5:0] MR   = 6'h14;
    localparam logic [5:0] RW0  = 6'h24;
    localparam logic [5:0] RW1  = 6'h25;
    localparam logic [5:0] RWMR = 6'h34;

    localparam logic [8:0] I_ADD   = 9'h000;
    localparam logic [8:0] I_LOAD  = 9'h040;
    localparam logic [8:0] I_STORE = 9'h060;
    localparam logic [8:0] I_OP7   = 9'h0E0;
    localparam logic [8:0] I_RST   = 9'h140;
    localparam logic [8:0] I_HALT  = 9'h160;
    localparam logic [8:0] I_BR    = 9'h180;
    localparam logic [8:0] I_UNDEF = 9'h1E0;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [PC_W-1:0] InstrAddr;
    logic [8:0]      Instr;
    logic [3:0]      AluOp;
    logic [7:0]      AluOut;
    logic            AluOverflow;
    logic            OverflowIn;
    logic            BranchFlag;
    logic            RegWrEn;
    logic            MemRdEn;
    logic            MemWrEn;
    logic            Busy;
    logic            Done;
    logic [15:0]     CycleCount;

    logic [8:0] imem     [256];
    logic [7:0] aout_mem [256];
    logic       ovf_mem  [256];
    logic       br_mem   [256];

    assign Instr       = imem[InstrAddr];
    assign AluOut      = aout_mem[InstrAddr];
    assign AluOverflow = ovf_mem[InstrAddr];
    assign BranchFlag  = br_mem[InstrAddr];

    alu_sequencer #(.PC_W(PC_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .InstrAddr   (InstrAddr),
        .Instr       (Instr),
        .AluOp       (AluOp),
        .AluOut      (AluOut),
        .AluOverflow (AluOverflow),
        .OverflowIn  (OverflowIn),
        .BranchFlag  (BranchFlag),
        .RegWrEn     (RegWrEn),
        .MemRdEn     (MemRdEn),
        .MemWrEn     (MemWrEn),
        .Busy        (Busy),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [17:0] observe();
        return {InstrAddr, AluOp, RegWrEn, MemRdEn, MemWrEn, Busy, Done, OverflowIn};
    endfunction

    task automatic ex(input string tag, input logic [7:0] a, input logic [3:0] op,
                      input logic [5:0] f);
        exp_t e;
        e.tag = tag;
        e.vec = {a, op, f};
        sb.push_back(e);
    endtask

    task automatic pop_now();
        exp_t        e;
        logic [17:0] obs;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=queued_entry", observe());
        end else begin
            e   = sb.pop_front();
            obs = observe();
            assert (obs === e.vec) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge Clk);
            pop_now();
        end
    endtask

    task automatic check_cc(input string tag, input int n);
        logic [15:0] want;
        want = CC_EN ? 16'(n) : 16'h0000;
        tests++;
        assert (CycleCount === want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, CycleCount, want);
        end
    endtask

    // Called right after a falling edge; Start is seen by exactly one rising edge.
    task automatic start_pulse();
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i]     = I_HALT;
            aout_mem[i] = 8'h00;
            ovf_mem[i]  = 1'b0;
            br_mem[i]   = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        clear_mem();

        // Reset values
        #3;
        ex("reset_state", 8'h00, 4'h0, IDL);
        pop_now();
        check_cc("cc_reset", 0);
        @(negedge Clk);
        Reset = 1'b0;
        ex("idle", 8'h00, 4'h0, IDL);
        cycles(1);

        // Program A: add (overflow 1), add (overflow 0), halt
        imem[0] = I_ADD; ovf_mem[0] = 1'b1;
        imem[1] = I_ADD; ovf_mem[1] = 1'b0;
        imem[2] = I_HALT;
        ex("A0_fetch", 8'h00, 4'h0, B0);  ex("A0_exec", 8'h00, 4'h0, B0);
        ex("A0_wb",    8'h00, 4'h0, RW0);
        ex("A1_fetch", 8'h01, 4'h0, B1);  ex("A1_exec", 8'h01, 4'h0, B1);
        ex("A1_wb",    8'h01, 4'h0, RW1);
        ex("A2_fetch", 8'h02, 4'h0, B0);  ex("A2_exec", 8'h02, 4'hB, B0);
        ex("A_halted", 8'h02, 4'h0, DN);
        start_pulse();
        cycles(9);
        check_cc("cc_A", 8);
        ex("A_halted_hold", 8'h02, 4'h0, DN);
        cycles(1);
        check_cc("cc_A_hold", 8);

        // Program B: three undefined ops, load at PC 3, halt
        clear_mem();
        imem[0] = I_UNDEF; imem[1] = I_UNDEF; imem[2] = I_UNDEF;
        imem[3] = I_LOAD;  imem[4] = I_HALT;
        for (int p = 0; p < 3; p++) begin
            ex("B_undef_fetch", 8'(p), 4'h0, B0);
            ex("B_undef_exec",  8'(p), 4'hF, B0);
            ex("B_undef_wb",    8'(p), 4'hF, B0);
        end
        ex("B_ld_fetch", 8'h03, 4'h0, B0);  ex("B_ld_exec", 8'h03, 4'h2, B0);
        ex("B_ld_mem",   8'h03, 4'h2, MR);  ex("B_ld_wb",   8'h03, 4'h2, RWMR);
        ex("B_next_fetch", 8'h04, 4'h0, B0); ex("B_halt_exec", 8'h04, 4'hB, B0);
        ex("B_halted",   8'h04, 4'h0, DN);
        start_pulse();
        cycles(16);
        check_cc("cc_B", 15);

        // Program C: taken branch, not-taken branch, store, add, store, rst, halt
        clear_mem();
        imem[8'h00] = I_BR;    aout_mem[8'h00] = 8'h20; br_mem[8'h00] = 1'b1;
        imem[8'h20] = I_BR;    aout_mem[8'h20] = 8'h55; br_mem[8'h20] = 1'b0;
        imem[8'h21] = I_STORE; ovf_mem[8'h21]  = 1'b1;
        imem[8'h22] = I_ADD;   ovf_mem[8'h22]  = 1'b1;
        imem[8'h23] = I_STORE;
        imem[8'h24] = I_RST;   ovf_mem[8'h24]  = 1'b1;
        imem[8'h25] = I_HALT;
        ex("C_br_fetch",  8'h00, 4'h0, B0);  ex("C_br_exec",  8'h00, 4'hC, B0);
        ex("C_br_wb",     8'h00, 4'hC, B0);
        ex("C_brn_fetch", 8'h20, 4'h0, B0);  ex("C_brn_exec", 8'h20, 4'hC, B0);
        ex("C_brn_wb",    8'h20, 4'hC, B0);
        ex("C_st_fetch",  8'h21, 4'h0, B0);  ex("C_st_exec",  8'h21, 4'h3, B0);
        ex("C_st_wb",     8'h21, 4'h3, MW0);
        ex("C_add_fetch", 8'h22, 4'h0, B0);  ex("C_add_exec", 8'h22, 4'h0, B0);
        ex("C_add_wb",    8'h22, 4'h0, RW0);
        ex("C_st2_fetch", 8'h23, 4'h0, B1);  ex("C_st2_exec", 8'h23, 4'h3, B1);
        ex("C_st2_wb",    8'h23, 4'h3, MW1);
        ex("C_rst_fetch", 8'h24, 4'h0, B1);  ex("C_rst_exec", 8'h24, 4'hA, B1);
        ex("C_rst_wb",    8'h24, 4'hA, B1);
        ex("C_h_fetch",   8'h25, 4'h0, B0);  ex("C_h_exec",   8'h25, 4'hB, B0);
        ex("C_halted",    8'h25, 4'h0, DN);
        start_pulse();
        cycles(21);
        check_cc("cc_C", 20);

        // Program D: branch to 0xFE, fall through to 0xFF, wrap to 0x00;
        // a Start pulse while busy must be ignored.
        clear_mem();
        imem[8'h00] = I_BR;  aout_mem[8'h00] = 8'hFE; br_mem[8'h00] = 1'b1;
        imem[8'hFE] = I_BR;  aout_mem[8'hFE] = 8'h10; br_mem[8'hFE] = 1'b0;
        imem[8'hFF] = I_OP7;
        ex("D_br_fetch",  8'h00, 4'h0, B0);  ex("D_br_exec",  8'h00, 4'hC, B0);
        ex("D_br_wb",     8'h00, 4'hC, B0);
        ex("D_fe_fetch",  8'hFE, 4'h0, B0);  ex("D_fe_exec",  8'hFE, 4'hC, B0);
        ex("D_fe_wb",     8'hFE, 4'hC, B0);
        ex("D_ff_fetch",  8'hFF, 4'h0, B0);  ex("D_ff_exec",  8'hFF, 4'h7, B0);
        ex("D_ff_wb",     8'hFF, 4'h7, RW0);
        ex("D_wrap_fetch", 8'h00, 4'h0, B0); ex("D_h_exec",   8'h00, 4'hB, B0);
        ex("D_halted",    8'h00, 4'h0, DN);
        start_pulse();
        cycles(2);
        imem[8'h00] = I_HALT;  // IR already holds the branch
        cycles(2);
        Start = 1'b1;
        cycles(1);
        Start = 1'b0;
        cycles(7);
        check_cc("cc_D", 11);

        // Program E: asynchronous reset during EXEC of an add at PC 1
        clear_mem();
        imem[0] = I_ADD; ovf_mem[0] = 1'b1;
        imem[1] = I_ADD; ovf_mem[1] = 1'b0;
        ex("E0_fetch", 8'h00, 4'h0, B0);  ex("E0_exec", 8'h00, 4'h0, B0);
        ex("E0_wb",    8'h00, 4'h0, RW0);
        ex("E1_fetch", 8'h01, 4'h0, B1);  ex("E1_exec", 8'h01, 4'h0, B1);
        start_pulse();
        cycles(5);
        #2 Reset = 1'b1;
        #1;
        ex("E_async_reset", 8'h00, 4'h0, IDL);
        pop_now();
        check_cc("cc_E_reset", 0);
        @(negedge Clk);
        Reset = 1'b0;
        ex("E_idle1", 8'h00, 4'h0, IDL);
        ex("E_idle2", 8'h00, 4'h0, IDL);
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
